jk_bank_ctrl: RTL

Command-driven sequencer for a bank of WIDTH JK flip-flop cells. It accepts one operation at a time over a valid/ready handshake and drives per-bit J/K each cycle for a programmed step count, so the bank can act as a loadable register, mask toggler, up/down counter or shift register. It sits between the control logic and the JK storage in the sequential library and is the only writer of the bank.

---
 rtl/jk_bank_pkg.sv | 27 ++
 rtl/jk_cell.sv | 26 ++
 rtl/jk_bank_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank sequencer: opcodes, FSM states, JK codes.
// Imported by jk_cell and jk_bank_ctrl.
package jk_bank_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_INC    = 3'd4,
    OP_DEC    = 3'd5,
    OP_SHL    = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop, sync active-low reset to 0.
// Ports: clk, reset, j, k in; q out.
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving a bank of WIDTH JK cells for N steps.
// Ports: clk, reset (sync, low), cmd_valid/ready/op/arg/steps, q, busy, done.
// Option: JK_BANK_CTRL_SAT_EN makes INC/DEC saturate instead of wrap.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [STEPW-1:0] cmd_steps,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] arg_q;
  logic [STEPW-1:0] cnt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] borrow;
  logic             sat_hold;

  // carry[i] = &q[i-1:0], borrow[i] = &~q[i-1:0]
  always_comb begin
    logic c;
    logic b;
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i]  = c;
      borrow[i] = b;
      c = c & q[i];
      b = b & ~q[i];
    end
  end

`ifdef JK_BANK_CTRL_SAT_EN
  // Saturated steps still burn a cycle so done timing is unchanged.
  always_comb begin
    sat_hold = ((op_q == OP_INC) && (&q))
            || ((op_q == OP_DEC) && (q == '0));
  end
`else
  always_comb begin
    sat_hold = 1'b0;
  end
`endif

  always_comb begin
    j = '0;
    k = '0;
    if (state == RUN && !sat_hold) begin
      case (op_q)
        OP_LOAD: begin
          j = arg_q;
          k = ~arg_q;
        end
        OP_CLEAR: begin
          k = '1;
        end
        OP_TOGGLE: begin
          j = arg_q;
          k = arg_q;
        end
        OP_INC: begin
          j = carry;
          k = carry;
        end
        OP_DEC: begin
          j = borrow;
          k = borrow;
        end
        OP_SHL: begin
          j = {q[WIDTH-2:0], arg_q[0]};
          k = ~{q[WIDTH-2:0], arg_q[0]};
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_HOLD;
      arg_q     <= '0;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= RUN;
            op_q      <= op_e'(cmd_op);
            arg_q     <= cmd_arg;
            cnt       <= (cmd_steps == '0) ? STEPW'(1) : cmd_steps;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == STEPW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - STEPW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g])
    );
  end

endmodule
